// File: rtl/rr_mux_arbiter.sv
// Round-robin N:1 stream multiplexer with a single registered output slot.
// Define RR_MUX_ARBITER_ARB_HOLD_EN to keep a channel granted until its in_last beat.
module rr_mux_arbiter #(
  parameter int WIDTH     = 32,
  parameter int CHANNELS  = 4,
  localparam int SEL_WIDTH = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  input  logic [WIDTH*CHANNELS-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_last,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic [SEL_WIDTH-1:0]      out_sel,
  output logic                      out_last
);

  typedef enum logic {ARB, LOCK} state_t;

  state_t               state_q, state_d;
  logic [SEL_WIDTH-1:0] ptr_q, ptr_d;
  logic [SEL_WIDTH-1:0] grant_idx;
  logic [CHANNELS-1:0]  eligible;
  logic                 grant_found;
  logic                 free;
  logic                 accept;
  logic [WIDTH-1:0]     sel_data;
  logic                 sel_last;
  int                   best_rank;
  int                   rank;

  assign free   = !out_valid || out_ready;
  assign accept = free && grant_found && rst_n;

  // Rank 0 is the channel just after the pointer; lowest eligible rank wins.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    best_rank   = CHANNELS;
    rank        = 0;
    for (int i = 0; i < CHANNELS; i++) begin
      rank = (i > int'(ptr_q)) ? (i - int'(ptr_q) - 1)
                               : (i + CHANNELS - int'(ptr_q) - 1);
      if (eligible[i] && (rank < best_rank)) begin
        best_rank   = rank;
        grant_found = 1'b1;
        grant_idx   = SEL_WIDTH'(i);
      end
    end
  end

  always_comb begin
    sel_data = '0;
    sel_last = 1'b0;
    in_ready = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (grant_idx == SEL_WIDTH'(i)) begin
        sel_data    = in_data[i*WIDTH +: WIDTH];
        sel_last    = in_last[i];
        in_ready[i] = accept;
      end
    end
  end

`ifdef RR_MUX_ARBITER_ARB_HOLD_EN
  logic [SEL_WIDTH-1:0] lock_q, lock_d;

  // While locked, only the burst owner may be granted.
  always_comb begin
    eligible = in_valid;
    if (state_q == LOCK) begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (lock_q != SEL_WIDTH'(i)) eligible[i] = 1'b0;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    lock_d  = lock_q;
    case (state_q)
      ARB: begin
        if (accept) begin
          if (sel_last) begin
            ptr_d = grant_idx;
          end else begin
            state_d = LOCK;
            lock_d  = grant_idx;
          end
        end
      end
      LOCK: begin
        if (accept && sel_last) begin
          state_d = ARB;
          ptr_d   = lock_q;
        end
      end
      default: state_d = ARB;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) lock_q <= '0;
    else        lock_q <= lock_d;
  end
`else
  assign eligible = in_valid;

  always_comb begin
    state_d = ARB;
    ptr_d   = ptr_q;
    case (state_q)
      ARB:     if (accept) ptr_d = grant_idx;
      default: state_d = ARB;
    endcase
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ARB;
      ptr_q   <= SEL_WIDTH'(CHANNELS - 1);
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // Single-entry output slot; drains when nothing new is accepted.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      out_last  <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_data  <= sel_data;
      out_sel   <= grant_idx;
      out_last  <= sel_last;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
